// File: rtl/sqr_share_arb.sv
// sqr_share_arb: round-robin arbiter that shares one registered unsigned squarer among NumReq requesters.
// Optional build macro SQR_SHARE_PIPE_EN adds a PIPE state and a second operand register before the squarer.
//------------------------------------------------------------------------------
// Module   : sqr_share_arb (with helper sqr_uns)
// Purpose  : time-shared unsigned squarer with per-requester valid/ready channels
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module sqr_uns #(
  parameter int Width = 8,
  parameter int Speed = 1
) (
  input  logic [Width-1:0]   x,
  output logic [2*Width-1:0] p
);

  // Speed 1 (FAST) infers a single multiplier; anything else builds a shift-add array.
  generate
    if (Speed == 1) begin : g_fast
      assign p = {{Width{1'b0}}, x} * {{Width{1'b0}}, x};
    end else begin : g_small
      logic [2*Width-1:0] acc;
      logic [2*Width-1:0] xe;
      assign xe = {{Width{1'b0}}, x};
      always_comb begin
        acc = '0;
        for (int i = 0; i < Width; i++) begin
          if (x[i]) acc = acc + (xe << i);
        end
      end
      assign p = acc;
    end
  endgenerate

endmodule

module sqr_share_arb #(
  parameter int Width  = 8,
  parameter int NumReq = 4,
  parameter int Speed  = 1
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [NumReq-1:0]       req_valid_i,
  output logic [NumReq-1:0]       req_ready_o,
  input  logic [NumReq*Width-1:0] req_x_i,
  output logic [NumReq-1:0]       resp_valid_o,
  input  logic [NumReq-1:0]       resp_ready_i,
  output logic [2*Width-1:0]      resp_p_o,
  output logic                    busy_o
);

  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PIPE = 2'd1,
    S_CALC = 2'd2,
    S_RESP = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [PtrW-1:0]   ptr_q;
  logic [PtrW-1:0]   owner_q;
  logic [Width-1:0]  op_q;
  logic [2*Width-1:0] resp_p_q;

  logic              gnt_found;
  logic [PtrW-1:0]   gnt_idx;
  logic [NumReq-1:0] gnt_oh;
  logic [NumReq-1:0] owner_oh;
  logic [Width-1:0]  sel_x;
  logic [Width-1:0]  sqr_in;
  logic [2*Width-1:0] sqr_p;
  logic              take;
  int                scan_idx;

  // Rotating priority search starting at ptr_q.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = 0;
    for (int k = 0; k < NumReq; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= NumReq) scan_idx = scan_idx - NumReq;
      if (!gnt_found && req_valid_i[scan_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PtrW'(scan_idx);
      end
    end
  end

  always_comb begin
    gnt_oh   = '0;
    owner_oh = '0;
    sel_x    = '0;
    for (int i = 0; i < NumReq; i++) begin
      gnt_oh[i]   = (gnt_idx == PtrW'(i));
      owner_oh[i] = (owner_q == PtrW'(i));
      if (gnt_idx == PtrW'(i)) sel_x = req_x_i[i*Width +: Width];
    end
  end

  // No handshake is offered while reset is held, so every output reads zero then.
  always_comb begin
    state_d      = state_q;
    req_ready_o  = '0;
    resp_valid_o = '0;
    take         = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (gnt_found && rst_ni) begin
          take        = 1'b1;
          req_ready_o = gnt_oh;
`ifdef SQR_SHARE_PIPE_EN
          state_d     = S_PIPE;
`else
          state_d     = S_CALC;
`endif
        end
      end
      S_PIPE: state_d = S_CALC;
      S_CALC: state_d = S_RESP;
      S_RESP: begin
        resp_valid_o = owner_oh;
        if ((resp_ready_i & owner_oh) != '0) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q    <= '0;
      owner_q  <= '0;
      op_q     <= '0;
      resp_p_q <= '0;
    end else begin
      if (take) begin
        op_q    <= sel_x;
        owner_q <= gnt_idx;
        ptr_q   <= (gnt_idx == PtrW'(NumReq - 1)) ? '0 : gnt_idx + PtrW'(1);
      end
      if (state_q == S_CALC) resp_p_q <= sqr_p;
    end
  end

`ifdef SQR_SHARE_PIPE_EN
  logic [Width-1:0] op2_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op2_q <= '0;
    end else if (state_q == S_PIPE) begin
      op2_q <= op_q;
    end
  end

  assign sqr_in = op2_q;
`else
  assign sqr_in = op_q;
`endif

  sqr_uns #(
    .Width (Width),
    .Speed (Speed)
  ) u_sqr (
    .x (sqr_in),
    .p (sqr_p)
  );

  assign resp_p_o = resp_p_q;
  assign busy_o   = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: doc/sqr_share_arb.md
# sqr_share_arb

Shares a single combinational unsigned squarer (`SqrUns`, P = X²) between `NumReq` requesters. Each requester has its own valid/ready request and response channel. A round-robin arbiter grants one request at a time. The operand and the result are registered around the squarer, so the combinational path stays short and each requester sees a clean handshake. The block sits between several datapath clients and one shared arithmetic unit from the library.

## Interface
Parameters:
- `Width`, 8: operand width; the result is `2*Width` bits.
- `NumReq`, 4: number of requesters, ≥1.
- `Speed`, `lau_pkg::FAST`: passed unchanged to the squarer instance.

Ports:
- `clk_i` in 1: clock; single clock domain.
- `rst_ni` in 1: reset, asynchronous, active-low.
- `req_valid_i` in `NumReq`: per-requester request valid.
- `req_ready_o` out `NumReq`: per-requester request accepted; one-hot or zero.
- `req_x_i` in `NumReq*Width`: flattened operands; requester i occupies bits `[i*Width +: Width]`.
- `resp_valid_o` out `NumReq`: result valid, asserted only toward the owner; one-hot or zero.
- `resp_ready_i` in `NumReq`: per-requester result consumed.
- `resp_p_o` out `2*Width`: result register, shared by all requesters.
- `busy_o` out 1: high whenever the state is not IDLE.

## Operation
- Only one transaction is in flight at a time.
- State machine: IDLE → (PIPE) → CALC → RESP → IDLE.
- **IDLE**
  - Grant g = the first i with `req_valid_i[i]=1`, searching from `ptr` upward modulo `NumReq`.
  - `req_ready_o[g]=1` combinationally in the same cycle. The handshake completes in that cycle.
  - On the clock edge: operand register ← `req_x_i[g]`, owner ← g, `ptr` ← (g+1) mod `NumReq`.
  - Next state is CALC, or PIPE when `SQR_SHARE_PIPE_EN` is defined.
  - With no valid request, the block stays in IDLE and all `req_ready_o` are 0.
- **PIPE** (only with the macro): the operand is moved into a second register. Next state is CALC.
- **CALC**
  - The squarer evaluates the operand register.
  - `resp_p_o` ← the squarer's P on the edge. Next state is RESP.
- **RESP**
  - `resp_valid_o[owner]=1`; all other bits are 0.
  - When `resp_ready_i[owner]=1`, the next state is IDLE.
  - `resp_ready_i` of non-owners is ignored.
- `req_ready_o` is 0 in every state except IDLE. A requester may hold `req_valid_i` high across a busy period.
- Arithmetic:
  - The result is the exact unsigned square; there is no truncation.
  - X=0 gives 0.
  - X=2^Width−1 gives 2^(2·Width) − 2^(Width+1) + 1.
- Reset values (asynchronous):
  - state IDLE, `ptr`=0, owner=0;
  - operand registers = 0, `resp_p_o`=0;
  - all `resp_valid_o`=0, `busy_o`=0.
- Reset mid-transaction aborts it immediately. The result is discarded and no response is issued.
- With `NumReq`=1, `ptr` stays 0 and arbitration is trivial.

## Timing
- Request handshake in cycle k produces `resp_valid_o` high from cycle k+2 (k+3 with `SQR_SHARE_PIPE_EN`).
- Response handshake in cycle m puts the block in IDLE in cycle m+1. The next grant can happen in m+1.
- Minimum issue interval is 3 cycles (4 with the macro).
- `resp_p_o` holds the last result until the next CALC edge.
- Combinational paths:
  - `req_valid_i` → `req_ready_o` (arbiter only);
  - none from `resp_ready_i` to any output.
- The squarer sits in a register-to-register path.

## Configuration
- `SQR_SHARE_PIPE_EN` defined:
  - the PIPE state and the second operand register are present;
  - latency is grant+3;
  - this cuts fan-out from the request mux before the squarer for large `Width`.
- `SQR_SHARE_PIPE_EN` undefined:
  - PIPE and the second register are absent;
  - latency is grant+2.
- Arbitration and the handshake rules are identical in both builds.

## Test plan
- Single request, `Width`=8: req0 X=0xFF in cycle 0.
  - Required: `req_ready_o`=0001 in cycle 0.
  - Required: `resp_valid_o`=0001 and `resp_p_o`=0xFE01 from cycle 2 (3 with the macro), held until `resp_ready_i[0]`.
- Round-robin: all four `req_valid_i` held high with X=i+1 and responses always ready.
  - Required: grants in order 0,1,2,3,0.
  - Required: results 1,4,9,16,1, each delivered to the matching owner only.
- Backpressure: owner's `resp_ready_i` held low 5 cycles, other requesters valid.
  - Required: `resp_valid_o` and `resp_p_o` stable.
  - Required: no `req_ready_o` asserted and `busy_o`=1 throughout.
- Non-owner ready: `resp_ready_i[2]=1` while the owner is 1 with ready low.
  - Required: no state change; `resp_valid_o`=0010 persists.
- Reset mid-op: `rst_ni` low during CALC.
  - Required: immediately all outputs 0 and `busy_o`=0.
  - Required: after release, the first grant goes to the lowest valid index from 0.
- Edge operands: X=0 gives `resp_p_o`=0; X=0x80 gives 0x4000. Checked against a behavioural X² model over 1000 random operands.
